// File: rtl/mc_pkg.sv
// Shared microcommand / flag index map for the controller-datapath interface.
package mc_pkg;

  localparam int unsigned NUM_UCMD  = 25;
  localparam int unsigned NUM_FLAGS = 5;

  // ucmd bit positions (bit k-1 carries controller output yk)
  localparam int unsigned UC_CLR_A = 0;
  localparam int unsigned UC_INC_A = 1;
  localparam int unsigned UC_DEC_A = 2;
  localparam int unsigned UC_LD_B  = 3;
  localparam int unsigned UC_ADD   = 4;
  localparam int unsigned UC_SUB   = 5;
  localparam int unsigned UC_SHL   = 7;
  localparam int unsigned UC_SHR   = 8;
  localparam int unsigned UC_LD_C  = 9;
  localparam int unsigned UC_DEC_C = 10;
  localparam int unsigned UC_EMIT  = 11;

  // x bit positions (bit k-1 carries flag xk)
  localparam int unsigned FL_AZERO     = 0;
  localparam int unsigned FL_ASIGN     = 1;
  localparam int unsigned FL_BGTA      = 2;
  localparam int unsigned FL_CNZ       = 3;
  localparam int unsigned FL_SLOT_FREE = 4;

  // A=0, C=0 and an empty slot after reset
  localparam logic [NUM_FLAGS-1:0] FLAGS_RST = 5'b10001;

endpackage

// File: rtl/mc_out_slot.sv
// Single-entry result register with valid/ready; flags results dropped on overrun.
module mc_out_slot #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             emit,
  input  logic [WIDTH-1:0] data,
  input  logic             ready,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic             valid_nxt_c,
  output logic             drop_c
);

  logic load_c;

  // A full slot only accepts new data when it is drained in the same cycle
  always_comb begin
    load_c      = emit & (~dout_valid | ready);
    drop_c      = emit & dout_valid & ~ready;
    valid_nxt_c = dout_valid;
    if (load_c) begin
      valid_nxt_c = 1'b1;
    end else if (ready) begin
      valid_nxt_c = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      dout_valid <= valid_nxt_c;
      if (load_c) begin
        dout <= data;
      end
    end
  end

endmodule

// File: rtl/mc_flag_datapath.sv
// Operational unit executing controller microcommands and returning branch flags x1..x5.
module mc_flag_datapath
  import mc_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned CW       = 4,
  parameter int unsigned CNT_INIT = 9
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_UCMD-1:0]  ucmd,
  input  logic [WIDTH-1:0]     din,
  input  logic                 din_valid,
  output logic                 din_ack,
  output logic [WIDTH-1:0]     dout,
  output logic                 dout_valid,
  input  logic                 dout_ready,
  output logic [NUM_FLAGS-1:0] x,
  output logic                 err
);

  logic [WIDTH-1:0]     a_q, a_nxt;
  logic [WIDTH-1:0]     b_q, b_nxt;
  logic [CW-1:0]        c_q, c_nxt;
  logic                 ld_b_ok_c;
  logic                 err_nxt;
  logic [NUM_FLAGS-1:0] x_nxt;
  logic                 slot_valid_nxt_c;
  logic                 slot_drop_c;
  logic                 unused_ucmd;

  assign unused_ucmd = ^{ucmd[NUM_UCMD-1:12], ucmd[6]};

  mc_out_slot #(.WIDTH(WIDTH)) u_out_slot (
    .clk         (clk),
    .rst         (rst),
    .emit        (ucmd[UC_EMIT]),
    .data        (a_q),
    .ready       (dout_ready),
    .dout        (dout),
    .dout_valid  (dout_valid),
    .valid_nxt_c (slot_valid_nxt_c),
    .drop_c      (slot_drop_c)
  );

  // Next-state for A/B/C; y5/y6 read the old B, A has a single priority winner
  always_comb begin
    a_nxt     = a_q;
    b_nxt     = b_q;
    c_nxt     = c_q;
    ld_b_ok_c = ucmd[UC_LD_B] & din_valid;

    if (ucmd[UC_CLR_A]) begin
      a_nxt = '0;
    end else if (ucmd[UC_ADD]) begin
      a_nxt = a_q + b_q;
    end else if (ucmd[UC_SUB]) begin
      a_nxt = a_q - b_q;
    end else if (ucmd[UC_SHL]) begin
      a_nxt = a_q << 1;
    end else if (ucmd[UC_SHR]) begin
      a_nxt = a_q >> 1;
    end else if (ucmd[UC_INC_A] ^ ucmd[UC_DEC_A]) begin
      a_nxt = ucmd[UC_INC_A] ? a_q + WIDTH'(1) : a_q - WIDTH'(1);
    end

    if (ld_b_ok_c) begin
      b_nxt = din;
    end

    if (ucmd[UC_LD_C]) begin
      c_nxt = CW'(CNT_INIT);
    end else if (ucmd[UC_DEC_C] && (c_q != '0)) begin
      c_nxt = c_q - CW'(1);
    end

    err_nxt = err | (ucmd[UC_LD_B] & ~din_valid) | slot_drop_c;

    // Flags track post-update state so they are valid right after this edge
    x_nxt               = '0;
    x_nxt[FL_AZERO]     = (a_nxt == '0);
    x_nxt[FL_ASIGN]     = a_nxt[WIDTH-1];
    x_nxt[FL_BGTA]      = (b_nxt > a_nxt);
    x_nxt[FL_CNZ]       = (c_nxt != '0);
    x_nxt[FL_SLOT_FREE] = ~slot_valid_nxt_c;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      din_ack <= 1'b0;
      err     <= 1'b0;
      x       <= FLAGS_RST;
    end else begin
      a_q     <= a_nxt;
      b_q     <= b_nxt;
      c_q     <= c_nxt;
      din_ack <= ld_b_ok_c;
      err     <= err_nxt;
      x       <= x_nxt;
    end
  end

endmodule

// File: doc/mc_flag_datapath.md
Name: mc_flag_datapath

Overview:
- Operational unit at the far end of the microcommand interface. It consumes the 25-line microcommand word (y1..y25) issued by our Mealy microprogram controllers and executes the encoded micro-operations on a small datapath.
- Returns the 5 logical condition flags (x1..x5) that the controller branches on. Closes the controller/datapath loop for system-level simulation and FPGA bring-up.
- Includes an operand-input handshake and a result-output handshake.

Parameters:
WIDTH, 8, width of accumulator A, operand B, din, dout
CW, 4, width of loop counter C
CNT_INIT, 9, value loaded into C by y10 (must fit in CW bits)

Ports:
clk  in  1  clock; datapath updates on posedge (controller updates state on negedge, so ucmd is stable at posedge)
rst  in  1  reset, asynchronous, active-high
ucmd  in  25  microcommand; ucmd[k-1] = controller output yk
din  in  WIDTH  operand data
din_valid  in  1  operand available
din_ack  out  1  registered one-cycle pulse: operand consumed
dout  out  WIDTH  result data
dout_valid  out  1  result slot full
dout_ready  in  1  downstream accepts result
x  out  5  condition flags; x[k-1] = xk, registered
err  out  1  sticky protocol error, cleared only by rst

Behaviour:
- Reset (async): A=0, B=0, C=0, dout=0, dout_valid=0, din_ack=0, err=0, so x = 5'b10001 (x1=1, x5=1).
- All updates occur on posedge clk. Flags are derived from post-update registers, so the effect of a microcommand is visible on x one posedge later, before the controller's next negedge sample.
- A write, single winner per cycle, priority high to low:
  - y1: A<=0
  - y5: A<=A+B
  - y6: A<=A-B
  - y8: A<=A<<1
  - y9: A<=A>>1 (logical)
  - y2 xor y3: A<=A+1 / A-1
  - y2 and y3 together: hold
- All A arithmetic is modulo 2^WIDTH (wrap, no saturation). Lower-priority A ops in the same word are ignored, not queued.
- B:
  - y4 with din_valid=1: B<=din, din_ack=1 next cycle.
  - y4 with din_valid=0: B holds, err<=1.
  - B is read by y5/y6 before any same-cycle y4 update (old B).
- C:
  - y10: C<=CNT_INIT.
  - y11: C<=C-1, saturating at 0.
  - y10 and y11 together: y10 wins.
- Output slot:
  - y12 with dout_valid=0, or with dout_valid=1 and dout_ready=1: dout<=A (pre-update A of this cycle), dout_valid<=1.
  - y12 with dout_valid=1 and dout_ready=0: result dropped, dout unchanged, err<=1.
  - dout_ready=1 without y12: dout_valid<=0.
  - dout is held stable while dout_valid=1.
- Flags:
  - x1 = (A==0)
  - x2 = A[WIDTH-1]
  - x3 = (B > A), unsigned
  - x4 = (C!=0)
  - x5 = ~dout_valid
- y7, y13..y25: reserved, no effect. Any ucmd value is legal, with no X propagation.
- Reset asserted mid-operation: all state is cleared immediately. An in-flight dout is lost, and din_ack does not pulse.

Decomposition:
- Shared package mc_pkg holds:
  - microcommand bit-index constants (UC_CLR_A=0, UC_INC_A=1, ... UC_EMIT=11)
  - flag index constants (FL_AZERO..FL_SLOT_FREE)
  - NUM_UCMD=25, NUM_FLAGS=5
- One sub-module, mc_out_slot: the single-entry output register with valid/ready, drop detection and err pulse. It is reusable by sibling controller datapaths.

Test Plan:
- Reset check: assert rst mid-cycle with A=0x33 -> immediately A=0, x=5'b10001, err=0, dout_valid=0.
- Increment: y2 on 3 posedges from reset -> A=3, x1=0. Then y2+y3 together -> A stays 3.
- Load and subtract: din=0x05, din_valid=1, y4 -> B=5, din_ack pulses 1 cycle. Then y6 (A=3) -> A=0xFE, x2=1, x3=0.
- Counter: y10 -> C=9, x4=1. Then 9×y11 -> C=0, x4=0. A 10th y11 -> C stays 0.
- Output overrun: A=0x2A, dout_ready=0, y12 -> dout=0x2A, dout_valid=1, x5=0. A second y12 -> err=1, dout stays 0x2A. Then dout_ready=1 -> dout_valid=0, x5=1.
- Priority: ucmd with y1|y5|y2 set, A=7, B=1 -> A=0 (y1 wins). y4 with din_valid=0 -> err=1, B unchanged.
